acc_pingpong_buf: RTL and testbench

//  Accumulates signed partial-sum rows from the PE array across K tiles into a 16x16 output tile.

---
 rtl/acc_pingpong_buf_if.sv | 37 +++
 rtl/acc_pingpong_buf.sv | 174 +++++++++++++++++
 tb/tb_acc_pingpong_buf.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_pingpong_buf_if.sv
// acc_pingpong_buf_if
//   Bundles the partial-sum input handshake and the PPU-facing drain stream.
//   master : partial-sum source / PPU side (drives i_*, observes o_*)
//   slave  : acc_pingpong_buf (observes i_*, drives o_*)
//   i_psum_valid/o_psum_ready : row handshake
//   i_psum_data               : signed partial sums, lane g = [g*PSUM_W +: PSUM_W]
//   i_psum_first/i_psum_last  : first / last K tile flags for the beat
//   i_ppu_ready               : PPU idle, may be started
//   o_ppu_start               : 1-cycle pulse, tile rows follow next cycle
//   o_acc_data/o_acc_valid    : drained row, lane g = [g*ACC_W +: ACC_W]
//   o_sat                     : 1-cycle pulse, a lane clamped on the accepted beat
interface acc_pingpong_buf_if #(
    parameter int LANES  = 16,
    parameter int PSUM_W = 20,
    parameter int ACC_W  = 24
);
    logic                      i_psum_valid;
    logic                      o_psum_ready;
    logic [PSUM_W*LANES-1:0]   i_psum_data;
    logic                      i_psum_first;
    logic                      i_psum_last;
    logic                      i_ppu_ready;
    logic                      o_ppu_start;
    logic [ACC_W*LANES-1:0]    o_acc_data;
    logic                      o_acc_valid;
    logic                      o_sat;

    modport master (
        output i_psum_valid, i_psum_data, i_psum_first, i_psum_last, i_ppu_ready,
        input  o_psum_ready, o_ppu_start, o_acc_data, o_acc_valid, o_sat
    );

    modport slave (
        input  i_psum_valid, i_psum_data, i_psum_first, i_psum_last, i_ppu_ready,
        output o_psum_ready, o_ppu_start, o_acc_data, o_acc_valid, o_sat
    );
endinterface

// File: rtl/acc_pingpong_buf.sv
// acc_pingpong_buf
//   Accumulates signed partial-sum rows over K tiles into one of two tile
//   banks (ping-pong) and drains each completed tile to the PPU as a start
//   pulse followed by ROWS consecutive rows.
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : acc_pingpong_buf_if.slave (psum handshake in, PPU stream out)
module acc_pingpong_buf #(
    parameter int LANES  = 16,
    parameter int ROWS   = 16,
    parameter int PSUM_W = 20,
    parameter int ACC_W  = 24
) (
    input  logic              i_clk,
    input  logic              i_rst,
    acc_pingpong_buf_if.slave bus
);
    localparam int RW = $clog2(ROWS);
    localparam logic signed [ACC_W:0] SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SUM_MIN = {2'b11, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DRAIN
    } state_e;

    // Tile storage; contents are not reset (first-K-tile beats overwrite).
    logic [ACC_W-1:0]       bank_q [2][ROWS][LANES];

    logic                   wbank_q;
    logic                   rbank_q;
    logic [1:0]             full_q;
    logic [1:0]             full_d;
    logic [RW-1:0]          wrow_q;
    logic [RW-1:0]          drow_q;
    logic [RW-1:0]          drain_idx;
    state_e                 state_q;
    logic                   ppu_start_q;
    logic                   acc_valid_q;
    logic [ACC_W*LANES-1:0] acc_data_q;
    logic                   sat_q;

    logic                   accept;
    logic                   tile_done;
    logic                   drain_done;
    logic                   sat_any;
    logic [ACC_W-1:0]       row_new [LANES];
    logic [ACC_W-1:0]       psum_ext;
    logic [ACC_W-1:0]       old_val;
    logic signed [ACC_W:0]  sum;
    logic [ACC_W*LANES-1:0] drain_row;

    assign accept    = bus.i_psum_valid & ~full_q[wbank_q];
    assign tile_done = accept & bus.i_psum_last & (wrow_q == RW'(ROWS-1));
    // drow_q has already wrapped to 0 while the final row is on the outputs.
    assign drain_done = (state_q == S_DRAIN) && (drow_q == '0);
    assign drain_idx  = (state_q == S_DRAIN) ? drow_q : '0;

    // Per-lane overwrite or saturating add for the beat at wrow_q.
    always_comb begin
        sat_any  = 1'b0;
        psum_ext = '0;
        old_val  = '0;
        sum      = '0;
        for (int unsigned g = 0; g < LANES; g++) begin
            psum_ext = {{(ACC_W-PSUM_W){bus.i_psum_data[g*PSUM_W+PSUM_W-1]}},
                        bus.i_psum_data[g*PSUM_W +: PSUM_W]};
            old_val  = bank_q[wbank_q][wrow_q][g];
            sum      = $signed({old_val[ACC_W-1], old_val}) + $signed({psum_ext[ACC_W-1], psum_ext});
            if (bus.i_psum_first) begin
                row_new[g] = psum_ext;
            end else if (sum > SUM_MAX) begin
                row_new[g] = {1'b0, {(ACC_W-1){1'b1}}};
                sat_any    = 1'b1;
            end else if (sum < SUM_MIN) begin
                row_new[g] = {1'b1, {(ACC_W-1){1'b0}}};
                sat_any    = 1'b1;
            end else begin
                row_new[g] = sum[ACC_W-1:0];
            end
        end
    end

    always_comb begin
        for (int unsigned g = 0; g < LANES; g++) begin
            drain_row[g*ACC_W +: ACC_W] = bank_q[rbank_q][drain_idx][g];
        end
    end

    // Fill and drain touch different banks, so both updates can land together.
    always_comb begin
        full_d = full_q;
        if (drain_done) full_d[rbank_q] = 1'b0;
        if (tile_done)  full_d[wbank_q] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            for (int unsigned g = 0; g < LANES; g++) begin
                bank_q[wbank_q][wrow_q][g] <= row_new[g];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wbank_q <= 1'b0;
            wrow_q  <= '0;
            full_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            full_q <= full_d;
            sat_q  <= accept & sat_any;
            if (accept) begin
                wrow_q <= (wrow_q == RW'(ROWS-1)) ? '0 : wrow_q + 1'b1;
            end
            if (tile_done) begin
                wbank_q <= ~wbank_q;
            end
        end
    end

    // Drain FSM. acc_data_q is loaded one cycle ahead: S_START loads row 0,
    // each S_DRAIN cycle loads the row after the one being presented.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            rbank_q     <= 1'b0;
            drow_q      <= '0;
            ppu_start_q <= 1'b0;
            acc_valid_q <= 1'b0;
            acc_data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (full_q[rbank_q] && bus.i_ppu_ready) begin
                        state_q     <= S_START;
                        ppu_start_q <= 1'b1;
                    end
                end
                S_START: begin
                    ppu_start_q <= 1'b0;
                    acc_valid_q <= 1'b1;
                    acc_data_q  <= drain_row;
                    drow_q      <= RW'(1);
                    state_q     <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (drain_done) begin
                        rbank_q     <= ~rbank_q;
                        acc_valid_q <= 1'b0;
                        if (full_q[~rbank_q] && bus.i_ppu_ready) begin
                            state_q     <= S_START;
                            ppu_start_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        acc_data_q <= drain_row;
                        drow_q     <= (drow_q == RW'(ROWS-1)) ? '0 : drow_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.o_psum_ready = ~full_q[wbank_q];
    assign bus.o_ppu_start  = ppu_start_q;
    assign bus.o_acc_valid  = acc_valid_q;
    assign bus.o_acc_data   = acc_data_q;
    assign bus.o_sat        = sat_q;
endmodule

// File: tb/tb_acc_pingpong_buf.sv
// tb_acc_pingpong_buf
//   Directed bench for acc_pingpong_buf: a tile-FIFO model predicts every
//   output cycle by cycle; directed checks pin hand-computed values.
module tb_acc_pingpong_buf;
    localparam int LANES  = 16;
    localparam int ROWS   = 16;
    localparam int PSUM_W = 20;
    localparam int ACC_W  = 24;
    localparam longint ACC_MAX = 8388607;
    localparam longint ACC_MIN = -8388608;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_acc_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    acc_pingpong_buf_if #(.LANES(LANES), .PSUM_W(PSUM_W), .ACC_W(ACC_W)) bus ();

    acc_pingpong_buf #(
        .LANES(LANES), .ROWS(ROWS), .PSUM_W(PSUM_W), .ACC_W(ACC_W)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: FIFO of completed tiles + drain phase ----------
    longint m_tiles [2][ROWS*LANES];
    longint m_fill  [ROWS*LANES];
    int     m_head = 0;
    int     m_cnt  = 0;
    int     m_wrow = 0;
    int     m_dcyc = -1;   // -1 idle, 0 start pulse, k>0 presenting row k-1
    bit     m_sat  = 1'b0;
    int     mc0;
    bit     macc;
    longint mp;
    longint mv;
    logic signed [PSUM_W-1:0] mps;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_head = 0; m_cnt = 0; m_wrow = 0; m_dcyc = -1; m_sat = 1'b0;
        end else begin
            mc0  = m_cnt;
            macc = bus.i_psum_valid && (mc0 < 2);
            if (m_dcyc < 0) begin
                if (mc0 > 0 && bus.i_ppu_ready) m_dcyc = 0;
            end else if (m_dcyc < ROWS) begin
                m_dcyc++;
            end else begin
                m_head ^= 1;
                m_cnt--;
                m_dcyc = (mc0 == 2 && bus.i_ppu_ready) ? 0 : -1;
            end
            m_sat = 1'b0;
            if (macc) begin
                for (int g = 0; g < LANES; g++) begin
                    mps = bus.i_psum_data[g*PSUM_W +: PSUM_W];
                    mp  = mps;
                    mv  = bus.i_psum_first ? mp : m_fill[m_wrow*LANES+g] + mp;
                    if (mv > ACC_MAX) begin mv = ACC_MAX; m_sat = 1'b1; end
                    else if (mv < ACC_MIN) begin mv = ACC_MIN; m_sat = 1'b1; end
                    m_fill[m_wrow*LANES+g] = mv;
                end
                if (m_wrow == ROWS-1 && bus.i_psum_last) begin
                    for (int i = 0; i < ROWS*LANES; i++) m_tiles[(m_head+m_cnt)%2][i] = m_fill[i];
                    m_cnt++;
                end
                m_wrow = (m_wrow + 1) % ROWS;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic signed [ACC_W-1:0] cmp_lane;
    always @(negedge clk) begin
        check("psum_ready", bus.o_psum_ready, (m_cnt < 2));
        check("ppu_start",  bus.o_ppu_start,  (m_dcyc == 0));
        check("acc_valid",  bus.o_acc_valid,  (m_dcyc >= 1));
        check("sat",        bus.o_sat,        m_sat);
        if (m_dcyc >= 1) begin
            for (int g = 0; g < LANES; g++) begin
                cmp_lane = bus.o_acc_data[g*ACC_W +: ACC_W];
                check("acc_data", cmp_lane, m_tiles[m_head][(m_dcyc-1)*LANES+g]);
            end
        end
    end

    // ---------------- event monitor for directed checks ----------------
    longint cap [ROWS][LANES];
    int     cap_r = 0;
    int     start_q[$];
    int     end_q[$];
    int     nvalid = 0;
    int     sat_cnt = 0;
    int     rise_cyc = -1;
    logic   prev_ready = 1'b1;
    logic signed [ACC_W-1:0] mon_lane;

    always @(negedge clk) begin
        if (bus.o_ppu_start) begin
            start_q.push_back(cyc);
            cap_r = 0;
        end
        if (bus.o_acc_valid) begin
            for (int g = 0; g < LANES; g++) begin
                mon_lane = bus.o_acc_data[g*ACC_W +: ACC_W];
                if (cap_r < ROWS) cap[cap_r][g] = mon_lane;
            end
            if (cap_r == ROWS-1) end_q.push_back(cyc);
            cap_r++;
            nvalid++;
        end
        if (bus.o_sat) sat_cnt++;
        if (bus.o_psum_ready && !prev_ready) rise_cyc = cyc;
        prev_ready = bus.o_psum_ready;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    function automatic logic [PSUM_W*LANES-1:0] mk_row(input int mode, input int r, input int val);
        logic [PSUM_W*LANES-1:0] d;
        int lv;
        d = '0;
        for (int g = 0; g < LANES; g++) begin
            lv = (mode == 0) ? r*16 + g : val;
            d[g*PSUM_W +: PSUM_W] = lv[PSUM_W-1:0];
        end
        return d;
    endfunction

    task automatic send_beat(input logic [PSUM_W*LANES-1:0] d, input logic f, input logic l);
        int budget;
        budget = 200;
        bus.i_psum_valid = 1'b1;
        bus.i_psum_data  = d;
        bus.i_psum_first = f;
        bus.i_psum_last  = l;
        while (!bus.o_psum_ready && budget > 0) begin tick(1); budget--; end
        if (budget == 0) check("beat_wait", budget, 1);
        tick(1);
        last_acc_cyc = cyc - 1;
        bus.i_psum_valid = 1'b0;
    endtask

    task automatic send_tile(input int mode, input int val, input logic f, input logic l);
        for (int r = 0; r < ROWS; r++) send_beat(mk_row(mode, r, val), f, l);
    endtask

    task automatic send_ktiles(input int val, input int k);
        for (int i = 0; i < k; i++) send_tile(1, val, (i == 0), (i == k-1));
    endtask

    task automatic wait_ends(input int target);
        int budget;
        budget = 400;
        while (end_q.size() < target && budget > 0) begin tick(1); budget--; end
        check("drain_wait", (end_q.size() >= target), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int s0, e0, t, sat0, nv0, s1;

    initial begin
        bus.i_psum_valid = 1'b0;
        bus.i_psum_data  = '0;
        bus.i_psum_first = 1'b0;
        bus.i_psum_last  = 1'b0;
        bus.i_ppu_ready  = 1'b1;
        #1 rst = 1'b1;
        tick(3);
        check("rst_acc_data_zero", (bus.o_acc_data == '0), 1);
        check("rst_psum_ready", bus.o_psum_ready, 1);
        rst = 1'b0;
        tick(2);

        // 1: single K tile, lane g of row r = r*16+g
        s0 = start_q.size(); e0 = end_q.size(); sat0 = sat_cnt;
        send_tile(0, 0, 1'b1, 1'b1);
        t = last_acc_cyc;
        wait_ends(e0 + 1);
        check("t1_start_latency", start_q[s0] - t, 2);
        check("t1_row_span", end_q[e0] - start_q[s0], 16);
        check("t1_r0g0", cap[0][0], 0);
        check("t1_r3g5", cap[3][5], 53);
        check("t1_r15g15", cap[15][15], 255);

        // 2: four K tiles of +3, then of -5
        e0 = end_q.size();
        send_ktiles(3, 4);
        wait_ends(e0 + 1);
        check("t2_pos", cap[7][9], 12);
        send_ktiles(-5, 4);
        wait_ends(e0 + 2);
        check("t2_neg_r0", cap[0][0], -20);
        check("t2_neg_r15", cap[15][3], -20);
        check("t2_no_sat", sat_cnt - sat0, 0);

        // 3: positive saturation, 16 adds fit, the next two clamp
        e0 = end_q.size(); sat0 = sat_cnt;
        send_ktiles(524287, 18);
        wait_ends(e0 + 1);
        check("t3_clamp_r0", cap[0][0], 8388607);
        check("t3_clamp_r15", cap[15][15], 8388607);
        check("t3_sat_pulses", sat_cnt - sat0, 32);

        // 4: both banks fill while PPU is busy
        bus.i_ppu_ready = 1'b0;
        s0 = start_q.size(); e0 = end_q.size();
        send_tile(0, 0, 1'b1, 1'b1);
        send_tile(1, 7, 1'b1, 1'b1);
        check("t4_ready_low", bus.o_psum_ready, 0);
        tick(5);
        check("t4_no_start", start_q.size() - s0, 0);
        bus.i_ppu_ready = 1'b1;
        wait_ends(e0 + 2);
        check("t4_start_spacing", start_q[s0+1] - start_q[s0], 17);
        check("t4_ready_rise", rise_cyc - end_q[e0], 1);
        check("t4_bank1_data", cap[4][4], 7);

        // 5: fill completes on the same cycle as the last drained row
        s0 = start_q.size(); e0 = end_q.size();
        send_tile(1, 1, 1'b1, 1'b1);
        tick(2);
        send_tile(1, 2, 1'b1, 1'b1);
        t = last_acc_cyc;
        wait_ends(e0 + 2);
        check("t5_same_cycle", end_q[e0], t);
        check("t5_next_start", start_q[s0+1] - t, 2);
        check("t5_data", cap[9][2], 2);

        // 6: reset at drained row 7 with a partial tile in the fill bank
        e0 = end_q.size(); nv0 = nvalid;
        send_tile(1, 9, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) send_beat(mk_row(1, 0, 4), 1'b1, 1'b0);
        tick(4);
        check("t6_rows_before_rst", nvalid - nv0, 7);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", bus.o_acc_valid, 0);
        check("t6_rst_start", bus.o_ppu_start, 0);
        check("t6_rst_data", (bus.o_acc_data == '0), 1);
        check("t6_rst_ready", bus.o_psum_ready, 1);
        tick(2);
        rst = 1'b0;
        s1 = start_q.size(); nv0 = nvalid;
        tick(40);
        check("t6_no_start_after_rst", start_q.size() - s1, 0);
        check("t6_no_valid_after_rst", nvalid - nv0, 0);
        send_tile(1, 11, 1'b1, 1'b1);
        wait_ends(e0 + 1);
        check("t6_new_tile", cap[5][5], 11);

        tick(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
